// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: parameter defaults, game channel
// indices and the arbiter state encoding.
package tick_sched_pkg;

    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_PERIOD_W = 16;
    localparam int unsigned DEF_PRESCALE = 100_000;  // 1 kHz base tick at 100 MHz

    // Channel assignment used by the game logic
    localparam int unsigned CH_TANK   = 0;
    localparam int unsigned CH_BULLET = 1;
    localparam int unsigned CH_SPAWN  = 2;
    localparam int unsigned CH_BLINK  = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: combinational rotate-priority search over a request vector.
// The search starts at last_grant+1 (mod NUM_CH) and wraps around.
// Ports:
//   req        in  NUM_CH  request vector
//   last_grant in  IDX_W   most recently granted index
//   win_c      out IDX_W   selected index (0 when nothing is requested)
//   found_c    out 1       at least one request is set
module rr_pick
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  win_c,
    output logic              found_c
);

    // Walk from farthest to nearest candidate so the nearest one is written last.
    always_comb begin
        win_c   = '0;
        found_c = 1'b0;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            if (req[IDX_W'((int'(last_grant) + k) % int'(NUM_CH))]) begin
                win_c   = IDX_W'((int'(last_grant) + k) % int'(NUM_CH));
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Periodic-event scheduler: prescaler-derived base tick drives NUM_CH
// programmable down-counters; expired channels are arbitrated round-robin
// onto a single valid/ready event port.
// Optional feature macro: TICK_SCHED_PAUSE_EN adds the 'pause' input that
// freezes the prescaler (and thus all channel counters).
// Ports:
//   clk, rst            clock, async active-low reset
//   pause               (TICK_SCHED_PAUSE_EN only) hold prescaler, no base_tick
//   cfg_we/cfg_ch/cfg_period  load period and remaining count of one channel
//   ch_en               per-channel run enable
//   evt_valid/evt_ch/evt_ready  event handshake
//   overrun             sticky per-channel overrun flags
//   ovr_clr             clear all overrun flags
//   base_tick           one-cycle pulse per prescaler period
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic                      pause,
`endif
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]       cfg_period,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic                      evt_valid,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    input  logic                      evt_ready,
    output logic [NUM_CH-1:0]         overrun,
    input  logic                      ovr_clr,
    output logic                      base_tick
);

    localparam int unsigned IDX_W  = $clog2(NUM_CH);
    localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

    logic pause_w;
`ifdef TICK_SCHED_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // ---------------- prescaler ----------------
    logic [PCNT_W-1:0] pcnt;
    logic              tick_c;

    // base_tick is a pure decode of the prescaler register
    assign tick_c    = (pcnt == PCNT_MAX) && !pause_w;
    assign base_tick = tick_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (!pause_w) begin
            pcnt <= (pcnt == PCNT_MAX) ? '0 : pcnt + PCNT_W'(1);
        end
    end

    // ---------------- channel counters ----------------
    logic [PERIOD_W-1:0] period    [NUM_CH];
    logic [PERIOD_W-1:0] remaining [NUM_CH];
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   cfg_hit_c;
    logic [NUM_CH-1:0]   expire_c;
    logic [NUM_CH-1:0]   decr_c;
    logic [NUM_CH-1:0]   accept_c;

    state_t           state;
    state_t           state_nx;
    logic             ack_c;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_c;
    logic             found_c;

    // A config write to a channel masks that channel's tick in the same cycle.
    always_comb begin
        cfg_hit_c = '0;
        expire_c  = '0;
        decr_c    = '0;
        accept_c  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cfg_hit_c[i] = cfg_we && (cfg_ch == IDX_W'(i));
            expire_c[i]  = tick_c && ch_en[i] && (period[i] != '0) && !cfg_hit_c[i]
                           && (remaining[i] == PERIOD_W'(1));
            decr_c[i]    = tick_c && ch_en[i] && (period[i] != '0) && !cfg_hit_c[i]
                           && (remaining[i] != PERIOD_W'(1));
            accept_c[i]  = ack_c && (evt_ch == IDX_W'(i));
        end
    end

    // Expiry beats accept on pending; overrun only when the old event is not leaving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                period[i]    <= '0;
                remaining[i] <= '0;
            end
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_hit_c[i]) begin
                    period[i]    <= cfg_period;
                    remaining[i] <= cfg_period;
                end else if (expire_c[i]) begin
                    remaining[i] <= period[i];
                end else if (decr_c[i]) begin
                    remaining[i] <= remaining[i] - PERIOD_W'(1);
                end

                if (expire_c[i]) begin
                    pending[i] <= 1'b1;
                end else if (accept_c[i]) begin
                    pending[i] <= 1'b0;
                end

                if (expire_c[i] && pending[i] && !accept_c[i]) begin
                    overrun[i] <= 1'b1;
                end else if (ovr_clr) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- arbiter ----------------
    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req        (pending),
        .last_grant (last_grant),
        .win_c      (pick_c),
        .found_c    (found_c)
    );

    // Next-state logic
    always_comb begin
        state_nx = state;
        ack_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    state_nx = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    ack_c    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and registered event outputs; evt_ch only moves in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= IDX_W'(NUM_CH - 1);
        end else begin
            state     <= state_nx;
            evt_valid <= (state_nx == ST_PRESENT);
            if ((state == ST_IDLE) && found_c) begin
                evt_ch <= pick_c;
            end
            if (ack_c) begin
                last_grant <= evt_ch;
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, NUM_CH=4.
// Cycle 0 is the first cycle after reset release; base ticks at 3, 7, 11, ...
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic [3:0]  ch_en;
    logic        evt_valid;
    logic [1:0]  evt_ch;
    logic        evt_ready;
    logic [3:0]  overrun;
    logic        ovr_clr;
    logic        base_tick;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int nv       = 0;

    tick_scheduler #(
        .PRESCALE (4),
        .NUM_CH   (4),
        .PERIOD_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .ch_en      (ch_en),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .base_tick  (base_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    // Wait up to max_cyc cycles for evt_valid, then check arrival cycle and channel.
    task automatic wait_evt(input string tag, input int max_cyc, input int exp_cyc,
                            input logic [1:0] exp_ch);
        int n;
        n = 0;
        while (!evt_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_ch"}, 32'(evt_ch), 32'(exp_ch));
    endtask

    initial begin
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = 2'd0;
        cfg_period = 16'd0;
        ch_en      = 4'h0;
        evt_ready  = 1'b0;
        ovr_clr    = 1'b0;

        // Reset state while rst is held low
        repeat (2) @(posedge clk);
        #1;
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_ch", 32'(evt_ch), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_base_tick", 32'(base_tick), 32'd0);
        rst = 1'b1;
        cyc = 0;

        // T1: base tick cadence, nothing configured
        for (int c = 0; c < 12; c++) begin
            check("t1_base_tick", 32'(base_tick), 32'((cyc % 4) == 3));
            check("t1_evt_valid", 32'(evt_valid), 32'd0);
            check("t1_overrun", 32'(overrun), 32'd0);
            tick();
        end

        // T2: ch1 period 3 written at cycle 12; expiries at 23, 35, 47
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_BULLET);
        cfg_period = 16'd3;
        ch_en      = 4'hF;
        evt_ready  = 1'b1;
        tick();
        cfg_we = 1'b0;
        wait_evt("t2_ev1", 40, 25, 2'd1);
        tick();
        check("t2_drop", 32'(evt_valid), 32'd0);
        wait_evt("t2_ev2", 20, 37, 2'd1);
        tick();
        wait_evt("t2_ev3", 20, 49, 2'd1);

        // T3: ch0 and ch2 expire together at cycle 7
        do_reset();
        ch_en      = 4'hF;
        evt_ready  = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_TANK);
        cfg_period = 16'd2;
        tick();
        cfg_ch = 2'(CH_SPAWN);
        tick();
        cfg_we = 1'b0;
        wait_evt("t3_ch0", 20, 9, 2'd0);
        tick();
        check("t3_gap", 32'(evt_valid), 32'd0);
        tick();
        wait_evt("t3_ch2", 0, 11, 2'd2);
        tick();
        // Second round: ch0 frozen, ch2 and ch3 both expire at 19, last_grant=2
        ch_en      = 4'b1110;
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_SPAWN);
        cfg_period = 16'd2;
        tick();
        cfg_ch = 2'(CH_BLINK);
        tick();
        cfg_we = 1'b0;
        wait_evt("t3_ch3", 20, 21, 2'd3);
        tick();
        tick();
        wait_evt("t3_ch2b", 0, 23, 2'd2);

        // T4: overrun with consumer stalled
        do_reset();
        ch_en      = 4'hF;
        evt_ready  = 1'b0;
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_BULLET);
        cfg_period = 16'd1;
        tick();
        cfg_we = 1'b0;
        wait_evt("t4_ev", 10, 5, 2'd1);
        tick();
        tick();
        check("t4_ovr_before", 32'(overrun), 32'd0);
        tick();
        check("t4_ovr_set", 32'(overrun), 32'h2);
        repeat (4) tick();
        check("t4_held_valid", 32'(evt_valid), 32'd1);
        check("t4_held_ch", 32'(evt_ch), 32'd1);
        check("t4_ovr_12", 32'(overrun), 32'h2);
        ch_en     = 4'h0;
        evt_ready = 1'b1;
        tick();
        check("t4_accepted", 32'(evt_valid), 32'd0);
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            if (evt_valid) nv++;
            tick();
        end
        check("t4_one_event", 32'(nv), 32'd0);
        check("t4_ovr_sticky", 32'(overrun), 32'h2);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t4_ovr_clr", 32'(overrun), 32'd0);

        // T5: config write collides with the tick that would expire ch0
        do_reset();
        ch_en      = 4'hF;
        evt_ready  = 1'b0;
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_TANK);
        cfg_period = 16'd1;
        tick();
        cfg_we = 1'b0;
        tick();
        tick();
        check("t5_tick_at_3", 32'(base_tick), 32'd1);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(CH_TANK);
        cfg_period = 16'd5;
        tick();
        cfg_we = 1'b0;
        wait_evt("t5_ev", 40, 25, 2'd0);
        tick();
        check("t5_hold_valid", 32'(evt_valid), 32'd1);
        check("t5_hold_ch", 32'(evt_ch), 32'd0);

        // T6: asynchronous reset while presenting
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(evt_valid), 32'd0);
        check("t6_async_ch", 32'(evt_ch), 32'd0);
        check("t6_async_ovr", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        cyc       = 0;
        ch_en     = 4'hF;
        evt_ready = 1'b1;
        nv        = 0;
        for (int c = 0; c < 10; c++) begin
            if (evt_valid) nv++;
            tick();
        end
        check("t6_pending_lost", 32'(nv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Periodic-event scheduler for the game logic. It derives a base tick from the system clock with an internal prescaler and runs NUM_CH programmable per-channel down-counters on that tick, one each for tank move, bullet step, enemy spawn and blink. Expired channels are arbitrated round-robin onto one valid/ready event port feeding the shared game-state update unit, so only one entity update is in flight at a time.

## Interface
- PRESCALE, 32'd100_000: clk cycles per base tick (1 kHz at 100 MHz); legal range ≥1.
- NUM_CH, 4: number of event channels; legal range 2..16.
- PERIOD_W, 16: width of the per-channel period, counted in base ticks.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  one-cycle write strobe; loads cfg_period into channel cfg_ch.
- cfg_ch  in  $clog2(NUM_CH)  channel index for the write.
- cfg_period  in  PERIOD_W  period in base ticks; 0 disables the channel.
- ch_en  in  NUM_CH  per-channel run enable; low freezes that channel's counter.
- evt_valid  out  1  an event is presented.
- evt_ch  out  $clog2(NUM_CH)  channel of the presented event.
- evt_ready  in  1  consumer accepts the event.
- overrun  out  NUM_CH  sticky flag: the channel expired while its previous event was still pending.
- ovr_clr  in  1  one-cycle pulse that clears all overrun bits.
- base_tick  out  1  one-cycle pulse per prescaler period, for debug and other users.

## Operation
- Prescaler: pcnt counts 0..PRESCALE-1 and then wraps to 0. base_tick = (pcnt == PRESCALE-1), giving a period of exactly PRESCALE cycles. With PRESCALE=1, base_tick is high every cycle.
- Per channel: period[i] (reset 0), remaining[i] (reset 0), pending[i] (reset 0).
- On a base_tick for a channel with ch_en[i]=1 and period[i]≠0:
  - If remaining[i]==1: set pending[i] and reload remaining[i] with period[i].
  - Otherwise: decrement remaining[i].
- Expiry while pending[i] is already 1: set overrun[i]. pending stays 1. Events are not queued beyond depth 1.
- cfg_we: period[cfg_ch] and remaining[cfg_ch] are both loaded with cfg_period. pending is unchanged. If cfg_we and base_tick hit the same channel in the same cycle, the config write wins and that tick is ignored for that channel.
- Arbiter FSM has two states:
  - IDLE: if any bit of pending is set, latch the round-robin winner into evt_ch, searching upward from last_grant+1 mod NUM_CH. Go to PRESENT.
  - PRESENT: evt_valid=1 and evt_ch is held stable. On evt_ready: clear pending[evt_ch], set last_grant=evt_ch, return to IDLE.
- If an accept and a new expiry hit the same channel in the same cycle, pending stays 1 and overrun is not set.
- If ovr_clr and an overrun set occur in the same cycle, the set wins.
- last_grant resets to NUM_CH-1, so channel 0 wins the first arbitration.

## Timing
- All outputs reset to 0: evt_valid, evt_ch, overrun, base_tick. FSM resets to IDLE and pcnt to 0.
- Asserting rst mid-operation clears everything immediately, including an in-flight evt_valid. Any pending event is lost.
- First base_tick occurs at cycle PRESCALE-1 after reset release.
- Expiry on a base_tick in cycle T: pending is set at T+1 and evt_valid rises at T+2.
- Maximum throughput is one event per 2 cycles, because IDLE is always visited between grants.
- evt_valid must not drop and evt_ch must not change until accepted.

## Configuration
- TICK_SCHED_PAUSE_EN defined: adds input port pause (1 bit). While pause=1, pcnt holds and base_tick is 0, so all channel counters freeze. The arbiter still drains pending events, and cfg writes still apply.
- TICK_SCHED_PAUSE_EN undefined: the pause port does not exist and the block behaves as if pause=0.

## Structure
- Package tick_sched_pkg holds:
  - FSM state enum (ST_IDLE, ST_PRESENT).
  - Defaults for NUM_CH, PERIOD_W and PRESCALE.
  - Channel index constants: CH_TANK=0, CH_BULLET=1, CH_SPAWN=2, CH_BLINK=3.
- Sub-module rr_pick: combinational rotate-priority search. Inputs are the request vector and last_grant; outputs are the winner index and a found flag.
- The prescaler and channel counters stay in the top module and use the async active-low reset.

## Test plan
Common bench settings: PRESCALE=4, NUM_CH=4.
- Reset release, no config -> base_tick high at cycles 3, 7, 11…; evt_valid stays 0 and overrun stays 4'b0.
- Write period=3 to ch1, ch_en=4'hF, evt_ready=1 -> first evt_valid with evt_ch=1 2 cycles after the 3rd base_tick, then one event every 12 cycles.
- ch0 and ch2 both set to period=2 and expiring on the same tick, evt_ready=1 -> ch0 is granted first, then ch2 2 cycles later. In a second round with ch2 and ch3 pending after last_grant=2, ch3 is granted before ch2.
- ch1 period=1 with evt_ready=0 for 12 cycles -> overrun[1]=1. Releasing ready delivers exactly one ch1 event. ovr_clr then returns overrun to 0.
- cfg_we (ch0, period=5) in the same cycle as a base_tick that would expire ch0 -> no event; next ch0 event arrives 5 ticks later.
- rst low while in PRESENT with evt_valid=1 -> evt_valid is 0 in the same cycle with no clk edge needed; pending is cleared.
